fft16_input_reorder: RTL and testbench
======================================

Name: fft16_input_reorder

Overview:
Upstream feeder for the radix-2 butterfly stage of the 16-point fixed-point FFT.
- Accepts one complex sample per cycle in natural order.
- Stores each sample at its 4-bit bit-reversed address.
- Once a full frame is loaded, emits 8 operand pairs (in0, in1) plus the stage-1 twiddle W^0, ready to drive butterfly2 ports directly.
- Single-bank buffer: it loads and drains alternately and does not overlap frames.

Parameters:
N, 16, word width of every real/imag sample, two's complement fixed point
Q, 8, fractional bits; twiddle 1.0 encoded as 1<<Q
POINTS, 16, frame length; power of 2
LOG2P, 4, log2(POINTS); bit-reverse width

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  reset; synchronous, active-high
i_valid  in  1  input sample valid
o_ready  out  1  block can accept a sample this cycle
i_re  in  N  input sample real part
i_im  in  N  input sample imag part
o_valid  out  1  output pair valid
i_ready  in  1  downstream accepts pair; tie high for free-running butterfly
o_in0_re  out  N  pair operand 0 real
o_in0_im  out  N  pair operand 0 imag
o_in1_re  out  N  pair operand 1 real
o_in1_im  out  N  pair operand 1 imag
o_twiddle_re  out  N  constant 1<<Q while o_valid, else 0
o_twiddle_im  out  N  constant 0
o_pair_idx  out  LOG2P-1  index k of current pair, 0..7
o_last  out  1  high with pair POINTS/2-1

Behaviour:
- Reset (sync, i_rst=1 at clock edge):
  - state=LOAD, wr_cnt=0, rd_cnt=0.
  - o_valid=0, o_last=0, o_pair_idx=0.
  - All data and twiddle outputs are 0; o_ready=1 from the next cycle.
  - Buffer contents are don't-care.
  - Reset mid-frame discards the partial or draining frame.
- State LOAD:
  - o_ready=1.
  - Accept when i_valid&&o_ready: mem[bitrev(wr_cnt)] <= {i_re,i_im}, then wr_cnt++.
  - i_valid gaps are allowed; nothing is written without a handshake.
  - On acceptance with wr_cnt==POINTS-1: next state DRAIN, wr_cnt wraps to 0.
  - o_ready drops to 0 the cycle after the 16th accept.
- State DRAIN:
  - o_ready=0; i_valid is ignored and the sample is dropped, not queued.
  - Output register advances when (!o_valid || i_ready).
  - On advance, load pair k=rd_cnt: in0=mem[2k], in1=mem[2k+1], o_pair_idx=k, o_last=(k==7), o_valid=1; then rd_cnt++.
  - Output is held stable while o_valid&&!i_ready.
  - After pair 7 is accepted (o_valid&&i_ready&&o_last): o_valid=0, state=LOAD, rd_cnt=0.
- Latency:
  - 16th sample accepted at edge T; pair 0 is valid at T+2.
  - With i_ready=1 throughout, pairs are emitted on consecutive cycles T+2..T+9.
  - o_ready returns to 1 at T+10.
- Frame period: at least 16 load cycles + 10, i.e. ≥26 cycles per frame.
- Arithmetic: none; data is passed bit-exact. Twiddle re = 1<<Q truncated to N bits.
- bitrev(a): reverse the LOG2P bits of a; e.g. bitrev(1)=8, bitrev(3)=12.

Decomposition:
- Shared package fft_pkg holds:
  - POINTS, LOG2P, the default N/Q;
  - the bitrev function;
  - the TWIDDLE_ONE constant (1<<Q).
- The storage array is a natural sub-module, fft_sample_ram:
  - POINTS x 2N register file;
  - one synchronous write port;
  - two combinational read ports.
- FSM and counters stay in the top module.

Test Plan:
- Reset: hold i_rst 3 cycles with random inputs -> o_valid=0, all data outputs 0; o_ready=1 after release.
- Full frame, sample n: re=n*256 (n<<Q), im=-n; i_ready=1 ->
  - pair0: in0=(0x0000,0x0000), in1=(0x0800,0xFFF8);
  - pair1: in0=x4 (0x0400,0xFFFC), in1=x12 (0x0C00,0xFFF4);
  - pair7: in0=(0x0700,0xFFF9), in1=(0x0F00,0xFFF1), o_last=1;
  - twiddle=(0x0100,0) on every valid cycle;
  - pair0 exactly 2 cycles after the 16th accept.
- Backpressure: i_ready=0 for 3 cycles at pair 3 -> outputs and o_pair_idx=3 held stable; no pair lost or duplicated; 8 pairs total.
- Bubbles/overrun: i_valid toggling 1010 during LOAD, then i_valid=1 held during DRAIN -> only handshaken samples stored; DRAIN-phase samples dropped; next frame starts clean.
- Reset mid-frame: i_rst after 9 samples, then a full new frame -> output reflects only the new frame.
- Back-to-back frames: two frames with distinct data -> o_ready low exactly 10 cycles between them (i_ready=1); second frame's pairs are correct.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and helpers for the 16-point fixed-point FFT datapath.
package fft_pkg;

  localparam int unsigned POINTS      = 16;
  localparam int unsigned LOG2P       = 4;
  localparam int unsigned N_DEF       = 16;
  localparam int unsigned Q_DEF       = 8;
  localparam int unsigned TWIDDLE_ONE = 32'd1 << Q_DEF;

  // Reverse the LOG2P address bits (bitrev(1)=8, bitrev(3)=12).
  function automatic logic [LOG2P-1:0] bitrev(input logic [LOG2P-1:0] a);
    logic [LOG2P-1:0] r;
    r = '0;
    for (int i = 0; i < int'(LOG2P); i++) begin
      r[i] = a[int'(LOG2P) - 1 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_sample_ram.sv
// Frame buffer: DEPTH x W register file, one synchronous write port and two
// combinational read ports (one per butterfly operand).
module fft_sample_ram
  import fft_pkg::*;
#(
  parameter int unsigned W     = 2 * N_DEF,
  parameter int unsigned DEPTH = POINTS,
  parameter int unsigned AW    = LOG2P
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr0,
  input  logic [AW-1:0] raddr1,
  output logic [W-1:0]  rdata0_c,
  output logic [W-1:0]  rdata1_c
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata0_c = mem[raddr0];
  assign rdata1_c = mem[raddr1];

endmodule

// File: rtl/fft16_input_reorder.sv
// Loads a natural-order frame into a bit-reversed buffer, then drains it as
// eight butterfly operand pairs with the stage-1 twiddle W^0.
module fft16_input_reorder
  import fft_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned Q = Q_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [N-1:0]       i_re,
  input  logic [N-1:0]       i_im,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [N-1:0]       o_in0_re,
  output logic [N-1:0]       o_in0_im,
  output logic [N-1:0]       o_in1_re,
  output logic [N-1:0]       o_in1_im,
  output logic [N-1:0]       o_twiddle_re,
  output logic [N-1:0]       o_twiddle_im,
  output logic [LOG2P-2:0]   o_pair_idx,
  output logic               o_last
);

  localparam int unsigned PW    = LOG2P - 1;
  localparam int unsigned DW    = 2 * N;
  localparam logic [N-1:0] TW_RE = N'(32'd1 << Q);

  localparam logic [0:0] S_LOAD  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  logic [0:0]       state, state_n;
  logic [LOG2P-1:0] wr_cnt, wr_cnt_n;
  logic [PW-1:0]    rd_cnt, rd_cnt_n;
  logic             wr_en_q, wr_en_n;
  logic [LOG2P-1:0] wr_addr_q, wr_addr_n;
  logic [DW-1:0]    wr_data_q, wr_data_n;
  logic             ready_n, valid_n, last_n;
  logic [PW-1:0]    idx_n;
  logic [DW-1:0]    in0_n, in1_n;
  logic [N-1:0]     tw_n;
  logic [DW-1:0]    rd0_c, rd1_c;

  fft_sample_ram #(.W(DW), .DEPTH(POINTS), .AW(LOG2P)) u_ram (
    .clk      (i_clk),
    .we       (wr_en_q),
    .waddr    (wr_addr_q),
    .wdata    (wr_data_q),
    .raddr0   ({rd_cnt, 1'b0}),
    .raddr1   ({rd_cnt, 1'b1}),
    .rdata0_c (rd0_c),
    .rdata1_c (rd1_c)
  );

  // Next-state and next-output logic; the write is staged one cycle, so the
  // drain waits until the last sample has landed in the buffer.
  always_comb begin
    state_n   = state;
    wr_cnt_n  = wr_cnt;
    rd_cnt_n  = rd_cnt;
    wr_en_n   = 1'b0;
    wr_addr_n = wr_addr_q;
    wr_data_n = wr_data_q;
    valid_n   = o_valid;
    last_n    = o_last;
    idx_n     = o_pair_idx;
    in0_n     = {o_in0_re, o_in0_im};
    in1_n     = {o_in1_re, o_in1_im};
    tw_n      = o_twiddle_re;

    unique case (state)
      S_LOAD: begin
        if (i_valid && o_ready) begin
          wr_en_n   = 1'b1;
          wr_addr_n = bitrev(wr_cnt);
          wr_data_n = {i_re, i_im};
          wr_cnt_n  = wr_cnt + LOG2P'(1);
          if (wr_cnt == LOG2P'(POINTS - 1)) begin
            state_n = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (o_valid && i_ready && o_last) begin
          valid_n  = 1'b0;
          last_n   = 1'b0;
          tw_n     = '0;
          rd_cnt_n = '0;
          state_n  = S_LOAD;
        end else if ((!o_valid || i_ready) && !wr_en_q) begin
          in0_n    = rd0_c;
          in1_n    = rd1_c;
          idx_n    = rd_cnt;
          last_n   = (rd_cnt == PW'(POINTS / 2 - 1));
          valid_n  = 1'b1;
          tw_n     = TW_RE;
          rd_cnt_n = rd_cnt + PW'(1);
        end
      end
      default: state_n = S_LOAD;
    endcase

    ready_n = (state_n == S_LOAD);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_LOAD;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      o_ready      <= 1'b1;
      o_valid      <= 1'b0;
      o_last       <= 1'b0;
      o_pair_idx   <= '0;
      o_in0_re     <= '0;
      o_in0_im     <= '0;
      o_in1_re     <= '0;
      o_in1_im     <= '0;
      o_twiddle_re <= '0;
    end else begin
      state        <= state_n;
      wr_cnt       <= wr_cnt_n;
      rd_cnt       <= rd_cnt_n;
      wr_en_q      <= wr_en_n;
      wr_addr_q    <= wr_addr_n;
      wr_data_q    <= wr_data_n;
      o_ready      <= ready_n;
      o_valid      <= valid_n;
      o_last       <= last_n;
      o_pair_idx   <= idx_n;
      {o_in0_re, o_in0_im} <= in0_n;
      {o_in1_re, o_in1_im} <= in1_n;
      o_twiddle_re <= tw_n;
    end
  end

  assign o_twiddle_im = '0;

endmodule

// File: tb/tb_fft16_input_reorder.sv
// Self-checking bench for fft16_input_reorder: random frames against a
// bit-reversal reference model, with bubbles, overrun, backpressure and resets.
module tb_fft16_input_reorder;

  localparam int unsigned W = 16;

  logic         i_clk = 1'b0;
  logic         i_rst, i_valid, i_ready;
  logic         o_ready, o_valid, o_last;
  logic [W-1:0] i_re, i_im;
  logic [W-1:0] o_in0_re, o_in0_im, o_in1_re, o_in1_im;
  logic [W-1:0] o_twiddle_re, o_twiddle_im;
  logic [2:0]   o_pair_idx;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] fre [16];
  logic [W-1:0] fim [16];
  logic [67:0]  obs [8];

  fft16_input_reorder dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_re         (i_re),
    .i_im         (i_im),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_in0_re     (o_in0_re),
    .o_in0_im     (o_in0_im),
    .o_in1_re     (o_in1_re),
    .o_in1_im     (o_in1_im),
    .o_twiddle_re (o_twiddle_re),
    .o_twiddle_im (o_twiddle_im),
    .o_pair_idx   (o_pair_idx),
    .o_last       (o_last)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // 4-bit reversal computed arithmetically from the bit weights.
  function automatic int rev4(input int a);
    return ((a & 1) * 8) + (((a >> 1) & 1) * 4) + (((a >> 2) & 1) * 2) + ((a >> 3) & 1);
  endfunction

  // Sample n lands at address rev4(n); pair k reads addresses 2k and 2k+1.
  function automatic logic [67:0] exp_pair(input int k);
    int a, b;
    a = rev4(2 * k);
    b = rev4(2 * k + 1);
    return {fre[a], fim[a], fre[b], fim[b], 3'(k), (k == 7)};
  endfunction

  task automatic random_frame();
    for (int n = 0; n < 16; n++) begin
      fre[n] = 16'($urandom);
      fim[n] = 16'($urandom);
    end
  endtask

  // Load one frame and drain it; outputs are observed at each falling edge
  // before the next inputs are driven.
  task automatic run_frame(input bit toggle_valid, input bit overrun,
                           input bit stall_mode, input bit chk_gap);
    int  sent, got, stalls, acc_edge, first_obs, low_cnt, cyc;
    bit  finished;
    sent = 0; got = 0; stalls = 0; acc_edge = -100; first_obs = -1;
    low_cnt = 0; cyc = 0; finished = 1'b0;
    for (int k = 0; k < 8; k++) obs[k] = '0;
    while (!finished) begin
      @(negedge i_clk);
      cyc++;
      if (cyc > 400) begin
        chk("timeout_pairs", 72'(got), 72'(8));
        break;
      end
      if (o_valid) begin
        if (first_obs < 0) begin
          first_obs = cyc;
          chk("pair0_latency", 72'(cyc), 72'(acc_edge + 3));
        end
        if (got < 8) begin
          obs[got] = {o_in0_re, o_in0_im, o_in1_re, o_in1_im, o_pair_idx, o_last};
          chk("pair", {o_in0_re, o_in0_im, o_in1_re, o_in1_im, o_pair_idx, o_last}, exp_pair(got));
        end else begin
          chk("extra_pair", 72'(o_valid), 72'(0));
        end
        chk("twiddle", {o_twiddle_re, o_twiddle_im}, {16'h0100, 16'h0000});
      end else begin
        chk("twiddle_idle", 72'(o_twiddle_re), 72'(0));
      end
      if (sent == 16 && !o_ready) low_cnt++;
      if (got == 8 && o_ready) finished = 1'b1;

      i_ready = 1'b1;
      i_valid = 1'b0;
      i_re    = 16'($urandom);
      i_im    = 16'($urandom);
      if (!finished) begin
        if (stall_mode && o_valid && got == 3 && stalls < 3) begin
          i_ready = 1'b0;
          stalls++;
        end
        if (o_valid && i_ready) got++;
        if (sent < 16) begin
          i_valid = toggle_valid ? ((cyc % 2) == 1) : 1'b1;
          if (i_valid && o_ready) begin
            i_re = fre[sent];
            i_im = fim[sent];
            sent++;
            if (sent == 16) acc_edge = cyc;
          end
        end else if (overrun) begin
          i_valid = 1'b1;
        end
      end
    end
    chk("pair_count", 72'(got), 72'(8));
    if (chk_gap) chk("ready_low_cycles", 72'(low_cnt), 72'(10));
    if (stall_mode) chk("stall_cycles", 72'(stalls), 72'(3));
  endtask

  initial begin
    // Reset held three cycles with random inputs.
    i_rst   = 1'b1;
    i_valid = 1'($urandom);
    i_ready = 1'($urandom);
    i_re    = 16'($urandom);
    i_im    = 16'($urandom);
    repeat (3) begin
      @(negedge i_clk);
      i_valid = 1'($urandom);
      i_ready = 1'($urandom);
      i_re    = 16'($urandom);
      i_im    = 16'($urandom);
    end
    chk("rst_valid", 72'(o_valid), 72'(0));
    chk("rst_last_idx", {o_last, o_pair_idx}, 72'(0));
    chk("rst_data", {o_in0_re, o_in0_im, o_in1_re, o_in1_im}, 72'(0));
    chk("rst_twiddle", {o_twiddle_re, o_twiddle_im}, 72'(0));
    i_rst   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge i_clk);
    chk("rst_ready", 72'(o_ready), 72'(1));
    chk("rst_valid_after", 72'(o_valid), 72'(0));

    // Ramp frame: re = n<<8, im = -n.
    for (int n = 0; n < 16; n++) begin
      fre[n] = 16'(n << 8);
      fim[n] = 16'(-n);
    end
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ramp_pair0", 72'(obs[0]), 72'({16'h0000, 16'h0000, 16'h0800, 16'hFFF8, 3'd0, 1'b0}));
    chk("ramp_pair1", 72'(obs[1]), 72'({16'h0400, 16'hFFFC, 16'h0C00, 16'hFFF4, 3'd1, 1'b0}));
    chk("ramp_pair7", 72'(obs[7]), 72'({16'h0700, 16'hFFF9, 16'h0F00, 16'hFFF1, 3'd7, 1'b1}));

    // Input bubbles during load, i_valid held during drain.
    random_frame();
    run_frame(1'b1, 1'b1, 1'b0, 1'b1);

    // Backpressure at pair 3.
    random_frame();
    run_frame(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset after nine samples, then a fresh frame.
    for (int n = 0; n < 9; n++) begin
      @(negedge i_clk);
      i_valid = 1'b1;
      i_re    = 16'($urandom);
      i_im    = 16'($urandom);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("midrst_valid", 72'(o_valid), 72'(0));
    chk("midrst_ready", 72'(o_ready), 72'(1));
    i_rst   = 1'b0;
    i_valid = 1'b0;
    random_frame();
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back frames with distinct data.
    random_frame();
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);
    random_frame();
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
